command_frame_decoder: RTL and testbench
========================================

Name: command_frame_decoder

Overview:
- Receive-side counterpart of the DAC sending unit: parses a 4-byte command frame from the UART RX byte stream into decoded control fields (valid, amount, increase/decrease, on/off).
- Holds one decoded command until the downstream consumer acknowledges it.
- Detects framing, checksum and inter-byte timeout errors, and drops bytes that arrive while a command is still pending.

Parameters:
- TIMEOUT_CYCLES, 100000, maximum clk cycles allowed between consecutive bytes of one frame before the frame is aborted (must be >= 2).
- SOF_BYTE, 8'hA5, start-of-frame byte value.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_data  input  8  received byte; qualified by rx_valid.
- rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle.
- cmd_ack  input  1  consumer has taken the pending command; sampled only while cmd_valid=1.
- cmd_valid  output  1  a decoded command is pending; high until acknowledged.
- cmd_amount  output  8  amount byte of the pending command.
- cmd_on  output  1  command byte bit0.
- cmd_off  output  1  command byte bit1.
- cmd_increase  output  1  command byte bit2.
- cmd_decrease  output  1  command byte bit3.
- frame_err  output  1  one-cycle pulse: checksum error, reserved-bit error or timeout.
- overrun  output  1  one-cycle pulse: byte dropped while a command was pending.
- err_count  output  8  saturating count of frame_err and overrun events.

Behaviour:
- Frame format: byte0 = SOF_BYTE; byte1 = CMD; byte2 = AMT; byte3 = CHK.
  - CMD[7:4] must be 0.
  - CHK = (CMD + AMT) mod 256.
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - All outputs 0: cmd_valid, cmd_amount, the four cmd flags, frame_err, overrun, err_count.
  - Timeout counter 0; internal byte registers 0.
  - Reset mid-frame or mid-HOLD discards everything.
- States: IDLE, GET_CMD, GET_AMT, GET_CHK, HOLD.
- IDLE:
  - rx_valid with rx_data==SOF_BYTE -> GET_CMD.
  - Any other byte is silently ignored: no error, no count.
- GET_CMD: rx_valid -> latch CMD -> GET_AMT.
- GET_AMT: rx_valid -> latch AMT -> GET_CHK.
- GET_CHK, on rx_valid:
  - If rx_data==(CMD+AMT)[7:0] and CMD[7:4]==0: load the output fields from CMD/AMT, cmd_valid=1 on the next cycle, -> HOLD.
  - Otherwise: frame_err pulse on the next cycle, -> IDLE, outputs unchanged.
- SOF handling: no resynchronisation. A SOF value received in GET_CMD, GET_AMT or GET_CHK is treated as data.
- Timeout:
  - The counter runs only in GET_CMD, GET_AMT and GET_CHK.
  - It clears on every accepted byte and on entry to GET_CMD.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_valid that cycle: -> IDLE, frame_err pulse.
  - rx_valid in that same cycle wins: the byte is processed and no timeout occurs.
- HOLD:
  - cmd_valid=1; cmd_amount and the flags are stable and unchanged.
  - cmd_ack=1 -> cmd_valid=0 on the next cycle, -> IDLE. Field outputs retain their last values; only cmd_valid qualifies them.
  - rx_valid without cmd_ack -> byte dropped, overrun pulse next cycle, state stays HOLD.
  - rx_valid and cmd_ack in the same cycle -> the ack is taken and the byte is evaluated as an IDLE byte. A SOF byte goes directly to GET_CMD and no overrun is flagged.
- cmd_ack outside HOLD is ignored.
- err_count:
  - +1 per frame_err or overrun pulse; saturates at 255 (no wrap).
  - frame_err and overrun are never both asserted in the same cycle.
- Field flags are passed through undecoded. Combinations such as on&off or inc&dec are forwarded as-is; arbitration is the consumer's job.
- Latency: cmd_valid rises on the cycle after the clk edge that samples the CHK byte.

Test Plan:
- Bytes A5,05,10,15 with gaps of 3 cycles -> one cycle after CHK: cmd_valid=1, cmd_amount=0x10, on=1, inc=1, off=0, dec=0. cmd_ack pulse -> cmd_valid=0 next cycle, state IDLE.
- Bytes A5,09,20,30 (bad CHK, expected 0x29) -> frame_err single pulse, cmd_valid stays 0, err_count=1. Then A5,12,01,13 (reserved bit set) -> frame_err, err_count=2.
- TIMEOUT_CYCLES=8; A5,05 then silence -> frame_err exactly 8 cycles after the 05 byte's strobe, state IDLE. A 05 strobe landing on the last counter cycle -> accepted, no error.
- Valid frame with no ack, then bytes 11,22 -> two overrun pulses, err_count=2, fields unchanged. Then ack together with rx_valid A5 -> cmd_valid falls, no overrun, next 06,07,0D -> new command, on=0, off=1, inc=1, amount=0x07.
- Garbage 00,FF,3C in IDLE -> no pulses, err_count unchanged. 300 bad-checksum frames -> err_count=255 (saturated).
- rst=1 asserted while in GET_AMT and while in HOLD -> next cycle all outputs 0. A following frame A5,05,10,15 decodes normally.

Source files
------------

// File: rtl/command_frame_decoder.sv
// command_frame_decoder: parses 4-byte UART command frames (SOF, CMD, AMT, CHK) into held control fields
// Ports: clk, rst (sync active-high); rx_data/rx_valid byte stream in; cmd_ack consumer handshake;
//        cmd_valid/cmd_amount/cmd_on/cmd_off/cmd_increase/cmd_decrease decoded command held until ack;
//        frame_err/overrun one-cycle error pulses; err_count saturating error tally.
module command_frame_decoder #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] SOF_BYTE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       cmd_ack,
  output logic       cmd_valid,
  output logic [7:0] cmd_amount,
  output logic       cmd_on,
  output logic       cmd_off,
  output logic       cmd_increase,
  output logic       cmd_decrease,
  output logic       frame_err,
  output logic       overrun,
  output logic [7:0] err_count
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {IDLE, GET_CMD, GET_AMT, GET_CHK, HOLD} state_t;
  state_t state;
  logic [TW-1:0] cnt;
  logic [7:0] cmd_b, amt_b;
  logic in_frame, chk_ok, timeout, fe_set, ov_set;
  always_comb begin
    in_frame = state == GET_CMD || state == GET_AMT || state == GET_CHK;
    chk_ok = rx_data == 8'(cmd_b + amt_b) && cmd_b[7:4] == 4'h0;
    // a byte arriving on the last counter cycle takes priority over the timeout
    timeout = in_frame && !rx_valid && cnt == TW'(TIMEOUT_CYCLES - 1);
    fe_set = timeout || (state == GET_CHK && rx_valid && !chk_ok);
    ov_set = state == HOLD && rx_valid && !cmd_ack;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      cmd_b <= '0;
      amt_b <= '0;
      cmd_valid <= 1'b0;
      cmd_amount <= '0;
      {cmd_decrease, cmd_increase, cmd_off, cmd_on} <= '0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
      err_count <= '0;
    end else begin
      frame_err <= fe_set;
      overrun <= ov_set;
      if ((fe_set || ov_set) && err_count != 8'hFF) err_count <= err_count + 8'd1;
      case (state)
        IDLE: if (rx_valid && rx_data == SOF_BYTE) begin
          state <= GET_CMD;
          cnt <= '0;
        end
        GET_CMD, GET_AMT, GET_CHK: if (rx_valid) begin
          cnt <= '0;
          if (state == GET_CMD) begin
            cmd_b <= rx_data;
            state <= GET_AMT;
          end else if (state == GET_AMT) begin
            amt_b <= rx_data;
            state <= GET_CHK;
          end else if (chk_ok) begin
            cmd_valid <= 1'b1;
            cmd_amount <= amt_b;
            {cmd_decrease, cmd_increase, cmd_off, cmd_on} <= cmd_b[3:0];
            state <= HOLD;
          end else state <= IDLE;
        end else if (timeout) state <= IDLE;
        else cnt <= cnt + TW'(1);
        HOLD: if (cmd_ack) begin
          // a byte coinciding with the ack is handled as if already in IDLE
          cmd_valid <= 1'b0;
          cnt <= '0;
          state <= (rx_valid && rx_data == SOF_BYTE) ? GET_CMD : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_command_frame_decoder.sv
// tb_command_frame_decoder: directed self-checking bench for command_frame_decoder
module tb_command_frame_decoder;
  logic clk = 0, rst = 0, rx_valid = 0, cmd_ack = 0;
  logic [7:0] rx_data = 0;
  logic cmd_valid, cmd_on, cmd_off, cmd_increase, cmd_decrease, frame_err, overrun;
  logic [7:0] cmd_amount, err_count;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  command_frame_decoder #(.TIMEOUT_CYCLES(8), .SOF_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .cmd_ack(cmd_ack),
    .cmd_valid(cmd_valid), .cmd_amount(cmd_amount), .cmd_on(cmd_on), .cmd_off(cmd_off),
    .cmd_increase(cmd_increase), .cmd_decrease(cmd_decrease), .frame_err(frame_err),
    .overrun(overrun), .err_count(err_count)
  );
  logic [3:0] flg;
  logic [21:0] outv;
  assign flg = {cmd_decrease, cmd_increase, cmd_off, cmd_on};
  assign outv = {cmd_valid, cmd_amount, flg, frame_err, overrun, err_count};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1;
    @(negedge clk);
    rx_valid = 0;
  endtask
  task automatic frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
    send(8'hA5);
    send(c);
    send(a);
    send(k);
  endtask
  task automatic ack();
    cmd_ack = 1;
    @(negedge clk);
    cmd_ack = 0;
  endtask
  task automatic reset();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask
  initial begin
    @(negedge clk);
    reset();
    check("reset_outputs", 32'(outv), 0);
    send(8'hA5); idle(3); send(8'h05); idle(3); send(8'h10); idle(3); send(8'h15);
    check("good_valid", 32'(cmd_valid), 1);
    check("good_amount", 32'(cmd_amount), 32'h10);
    check("good_flags", 32'(flg), 4'b0101);
    ack();
    check("ack_drop", 32'(cmd_valid), 0);
    check("ack_retain", 32'(cmd_amount), 32'h10);
    frame(8'h09, 8'h20, 8'h30);
    check("badchk_err", 32'({frame_err, cmd_valid}), 2'b10);
    check("badchk_cnt", 32'(err_count), 1);
    idle(1);
    check("badchk_pulse_end", 32'(frame_err), 0);
    frame(8'h12, 8'h01, 8'h13);
    check("resv_err", 32'({frame_err, cmd_valid}), 2'b10);
    check("resv_cnt", 32'(err_count), 2);
    send(8'hA5); send(8'h05);
    idle(7);
    check("tmo_early", 32'(frame_err), 0);
    idle(1);
    check("tmo_fire", 32'(frame_err), 1);
    check("tmo_cnt", 32'(err_count), 3);
    send(8'h05); send(8'h10); send(8'h15); idle(1);
    check("tmo_idle", 32'({err_count, cmd_valid, frame_err}), {8'd3, 2'b00});
    send(8'hA5); send(8'h05);
    idle(7);
    send(8'h10);
    check("tmo_last_byte", 32'(frame_err), 0);
    send(8'h15);
    check("tmo_last_valid", 32'({cmd_valid, cmd_amount, err_count}), {1'b1, 8'h10, 8'd3});
    ack();
    reset();
    frame(8'h05, 8'h10, 8'h15);
    send(8'h11);
    check("ovr1", 32'({overrun, err_count}), {1'b1, 8'd1});
    send(8'h22);
    check("ovr2", 32'({overrun, err_count}), {1'b1, 8'd2});
    idle(1);
    check("ovr_fields", 32'({overrun, cmd_valid, cmd_amount, flg}), {2'b01, 8'h10, 4'b0101});
    cmd_ack = 1; rx_data = 8'hA5; rx_valid = 1;
    @(negedge clk);
    cmd_ack = 0; rx_valid = 0;
    check("ack_sof", 32'({cmd_valid, overrun, err_count}), {2'b00, 8'd2});
    send(8'h06); send(8'h07); send(8'h0D);
    check("ack_sof_frame", 32'({cmd_valid, cmd_amount, flg}), {1'b1, 8'h07, 4'b0110});
    ack();
    send(8'h00);
    check("garbage0", 32'({frame_err, overrun, err_count}), {2'b00, 8'd2});
    send(8'hFF);
    check("garbageFF", 32'({frame_err, overrun, err_count}), {2'b00, 8'd2});
    send(8'h3C);
    check("garbage3C", 32'({frame_err, overrun, err_count}), {2'b00, 8'd2});
    for (int i = 0; i < 300; i++) frame(8'h00, 8'h00, 8'h01);
    check("saturate", 32'(err_count), 255);
    send(8'hA5); send(8'h05);
    reset();
    check("rst_get_amt", 32'(outv), 0);
    send(8'h10); send(8'h15); idle(1);
    check("rst_discard", 32'({cmd_valid, frame_err, err_count}), 0);
    frame(8'h05, 8'h10, 8'h15);
    reset();
    check("rst_hold", 32'(outv), 0);
    frame(8'h05, 8'h10, 8'h15);
    check("post_rst_frame", 32'({cmd_valid, cmd_amount, flg, err_count}), {1'b1, 8'h10, 4'b0101, 8'd0});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
